// File: rtl/lock_access_ctrl.sv
// Door-lock access controller: 'A' + PIN unlock, auto-relock,
// inter-byte entry timeout and lockout after repeated wrong PINs.
module lock_access_ctrl #(
  parameter int                   PIN_LEN        = 4,
  parameter logic [PIN_LEN*8-1:0] PIN_CODE       = 32'h31323334,
  parameter int                   MAX_FAILS      = 3,
  parameter logic [31:0]          OPEN_CYCLES    = 32'd250000000,
  parameter logic [31:0]          ENTRY_TIMEOUT  = 32'd150000000,
  parameter logic [31:0]          LOCKOUT_CYCLES = 32'd1500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       btn_close,
  output logic       lock_open,
  output logic       entry_active,
  output logic       locked_out,
  output logic       bad_pin,
  output logic [2:0] fail_count
);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, OPEN, LOCKOUT
  } state_t;

  localparam int IW = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(PIN_LEN - 1);
  localparam logic [2:0] MF = 3'(MAX_FAILS);
  localparam logic [7:0] CH_A = 8'h41;
  localparam logic [7:0] CH_C = 8'h43;

  state_t        state, state_n;
  logic [31:0]   timer, timer_n;
  logic [IW-1:0] idx, idx_n;
  logic          mism, mism_n;
  logic [2:0]    fail_n;
  logic          bad_n;

  logic       rxv_q;
  logic [7:0] rxb_q;
  logic       btn_q;
  logic       is_a, is_c, tdone;

  logic [7:0] pin_b [PIN_LEN];

  for (genvar g = 0; g < PIN_LEN; g++) begin : g_pin
    assign pin_b[g] = PIN_CODE[(PIN_LEN-1-g)*8 +: 8];
  end

  assign is_a  = rxv_q && (rxb_q == CH_A);
  assign is_c  = rxv_q && (rxb_q == CH_C);
  assign tdone = (timer == 32'd1);

  // Inputs are registered once; the FSM acts on the registered copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxv_q <= 1'b0;
      rxb_q <= 8'h00;
      btn_q <= 1'b0;
    end else begin
      rxv_q <= rx_valid;
      rxb_q <= rx_byte;
      btn_q <= btn_close;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    mism_n  = mism;
    fail_n  = fail_count;
    bad_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_a) begin
          state_n = ENTRY;
          idx_n   = '0;
          mism_n  = 1'b0;
          timer_n = ENTRY_TIMEOUT;
        end
      end
      ENTRY: begin
        if (btn_q || is_c) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (is_a) begin
          idx_n   = '0;
          mism_n  = 1'b0;
          timer_n = ENTRY_TIMEOUT;
        end else if (rxv_q) begin
          // Every byte is consumed so the failing position stays hidden.
          mism_n  = mism | (rxb_q != pin_b[idx]);
          idx_n   = idx + 1'b1;
          timer_n = ENTRY_TIMEOUT;
          if (idx == LAST) begin
            state_n = CHECK;
            timer_n = '0;
          end
        end else if (tdone) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      CHECK: begin
        if (!mism) begin
          state_n = OPEN;
          fail_n  = '0;
          timer_n = OPEN_CYCLES;
        end else begin
          bad_n  = 1'b1;
          fail_n = (fail_count >= MF) ? MF : fail_count + 3'd1;
          if (fail_n == MF) begin
            state_n = LOCKOUT;
            timer_n = LOCKOUT_CYCLES;
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end
      end
      OPEN: begin
        if (btn_q || is_c || tdone) begin
          state_n = IDLE;
          timer_n = '0;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      LOCKOUT: begin
        if (tdone) begin
          state_n = IDLE;
          fail_n  = '0;
          timer_n = '0;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      idx          <= '0;
      mism         <= 1'b0;
      fail_count   <= '0;
      bad_pin      <= 1'b0;
      lock_open    <= 1'b0;
      entry_active <= 1'b0;
      locked_out   <= 1'b0;
    end else begin
      state        <= state_n;
      timer        <= timer_n;
      idx          <= idx_n;
      mism         <= mism_n;
      fail_count   <= fail_n;
      bad_pin      <= bad_n;
      lock_open    <= (state_n == OPEN);
      entry_active <= (state_n == ENTRY);
      locked_out   <= (state_n == LOCKOUT);
    end
  end

endmodule

// File: doc/lock_access_ctrl.md
Name: lock_access_ctrl

Overview:
- Sits between the UART receiver (byte-valid strobe plus byte) and the door-lock actuator. Sequences unlocking and arbitrates between two requesters: the UART command stream and the local close button.
- Unlock requires 'A' followed by a PIN_LEN-byte PIN.
- Adds an auto-relock timer, an inter-byte entry timeout, and a lockout after repeated wrong PINs.

Parameters:
- PIN_LEN, 4, number of PIN bytes after 'A'.
- PIN_CODE, 32'h31323334, expected PIN ("1234"), PIN_LEN*8 bits, first byte in MSBs; must not contain 8'h41 or 8'h43.
- MAX_FAILS, 3, consecutive wrong PINs that trigger lockout (1..7).
- OPEN_CYCLES, 250000000, clocks lock stays open before auto-relock.
- ENTRY_TIMEOUT, 150000000, max clocks between bytes during PIN entry.
- LOCKOUT_CYCLES, 1500000000, clocks of lockout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- rx_valid  in  1  one-cycle strobe: rx_byte valid
- rx_byte  in  8  received byte
- btn_close  in  1  one-cycle local close request (already synchronised/debounced)
- lock_open  out  1  actuator drive, 1 = open
- entry_active  out  1  PIN entry in progress
- locked_out  out  1  lockout in progress
- bad_pin  out  1  one-cycle pulse on wrong-PIN verdict
- fail_count  out  3  consecutive wrong PINs

Behaviour:
- Reset (rst low, asynchronous): state IDLE; lock_open, entry_active, locked_out and bad_pin are 0; fail_count is 0; timer, index and mismatch flag are cleared. Reset mid-operation aborts everything, including OPEN; the lock closes immediately.
- All outputs are registered. There is one shared 32-bit down-counter timer, reloaded on each state entry.
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT.
- IDLE:
  - rx 'A' (8'h41) -> ENTRY; index = 0; mismatch = 0; timer = ENTRY_TIMEOUT.
  - Any other byte is ignored.
- ENTRY (entry_active = 1):
  - A non-'A'/'C' byte is compared with PIN_CODE byte[index]; any difference sets the sticky mismatch flag.
  - Every byte is consumed; there is no early reject, so the failing position is not revealed.
  - Each accepted byte increments index and reloads the timer.
  - The byte with index = PIN_LEN-1 -> CHECK.
  - 'C' -> IDLE, no fail counted.
  - 'A' -> restart entry: index = 0, mismatch cleared, timer reloaded.
  - Timer reaching 0 -> IDLE, no fail counted.
- CHECK (exactly 1 cycle), on !mismatch:
  - -> OPEN; lock_open = 1; fail_count = 0; timer = OPEN_CYCLES.
- CHECK, on mismatch:
  - bad_pin pulses for 1 cycle; fail_count increments.
  - If the new count == MAX_FAILS: -> LOCKOUT; timer = LOCKOUT_CYCLES; locked_out = 1.
  - Otherwise: -> IDLE.
- Latency: lock_open rises on the 2nd rising edge after the edge that samples the final PIN byte. bad_pin asserts on that same 2nd edge.
- OPEN:
  - 'C' or btn_close -> IDLE; lock_open falls on the next edge.
  - Timer reaching 0 -> IDLE; lock_open = 0.
  - 'A' and other bytes are ignored; the timer is not restarted.
- LOCKOUT:
  - All rx bytes and btn_close are ignored.
  - Timer reaching 0 -> IDLE; fail_count = 0; locked_out = 0.
- Arbitration: if btn_close and rx_valid occur in the same cycle, btn_close wins and the byte is discarded. btn_close outside OPEN has no effect, except in ENTRY, where it aborts to IDLE like 'C'.
- fail_count saturates at MAX_FAILS and is cleared only by a correct PIN, lockout expiry, or reset.
- Timer compare is "== 1 while decrementing", so the state dwells exactly N cycles.

Test Plan:
Bench parameters: PIN_LEN=4, PIN_CODE="1234", MAX_FAILS=3, OPEN_CYCLES=100, ENTRY_TIMEOUT=50, LOCKOUT_CYCLES=200.
- Correct PIN: send 'A','1','2','3','4' -> lock_open=1 on the 2nd edge after '4'; fail_count=0; lock_open stays 1 exactly 100 cycles, then 0.
- Early close: correct PIN, then 'C' at cycle 10 of OPEN -> lock_open=0 next edge. Repeat using btn_close: same result.
- Wrong PIN x3: 'A','1','2','9','4' three times -> bad_pin pulses three times; fail_count 1,2,3; locked_out=1. During lockout a correct PIN leaves lock_open=0. After 200 cycles: locked_out=0, fail_count=0, and a correct PIN then opens.
- Entry abort/timeout: 'A','1','2', then a 60-cycle gap -> entry_active=0, fail_count unchanged. 'A','1','C' -> IDLE, no bad_pin. 'A','1','A','1','2','3','4' -> opens.
- Simultaneous/reset: in OPEN, assert btn_close together with rx 'A' -> closes and the byte is ignored. Assert rst low mid-ENTRY and mid-OPEN -> all outputs 0 immediately (asynchronous); fail_count=0.
